// File: rtl/line_fill_pkg.sv
// Shared system-bus definitions: command/device codes, request tag
// composition and the line_fill state encoding.
package line_fill_pkg;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

    localparam int SYSBUS_TAG_W = 13;
    localparam int BEAT_CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDRREQ,
        WAITRESP,
        RESP,
        READY
    } line_fill_state_e;

    // Tag layout: command in bit 12, target device in bits 11:8.
    function automatic logic [SYSBUS_TAG_W-1:0] sysbus_tag(input logic       cmd,
                                                           input logic [3:0] dev);
        return {cmd, dev, 8'h00};
    endfunction

endpackage

// File: rtl/line_fill_if.sv
// System bus signals seen by the line fill engine: arbiter handshake,
// request channel and response channel.
interface line_fill_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      abtr_reqcyc;
    logic                      abtr_grant;
    logic                      bus_busy;
    logic                      main_bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] main_bus_req;
    logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag;
    logic                      main_bus_reqack;
    logic                      main_bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] main_bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag;
    logic                      main_bus_respack;

    modport master (
        output abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_req,
               main_bus_reqtag, main_bus_respack,
        input  abtr_grant, main_bus_reqack, main_bus_respcyc, main_bus_resp,
               main_bus_resptag
    );

    modport slave (
        input  abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_req,
               main_bus_reqtag, main_bus_respack,
        output abtr_grant, main_bus_reqack, main_bus_respcyc, main_bus_resp,
               main_bus_resptag
    );
endinterface

// File: rtl/line_fill_assembler.sv
// Beat counter and line register: each accepted beat lands in the slot
// selected by the counter, which then advances.
module line_fill_assembler
    import line_fill_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int LINE_BEATS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 accept,
    input  logic [BUS_DATA_WIDTH-1:0]            beat,
    output logic                                 last,
    output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] data
);

    logic [BEAT_CNT_W-1:0] cnt_q;
    logic [LINE_BEATS-1:0] beat_we;

    always_comb begin
        beat_we = '0;
        for (int k = 0; k < LINE_BEATS; k++) begin
            beat_we[k] = accept && (cnt_q == BEAT_CNT_W'(k));
        end
    end

    assign last = (cnt_q == BEAT_CNT_W'(LINE_BEATS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + BEAT_CNT_W'(1);
        end
    end

    // Line contents survive a restart until each slot is overwritten.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else begin
            for (int k = 0; k < LINE_BEATS; k++) begin
                if (beat_we[k]) begin
                    data[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= beat;
                end
            end
        end
    end

endmodule

// File: rtl/line_fill.sv
// Cache line fill engine: wins the bus, issues one line read and collects
// LINE_BEATS response beats. Define LINE_FILL_TAGCHK_EN to accept only read/memory-tagged beats.
module line_fill
    import line_fill_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [BUS_DATA_WIDTH-1:0]            addr,
    line_fill_if.master                          bus,
    output logic                                 ready,
    output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] data
);

    localparam int OFFSET_W = $clog2(BUS_DATA_WIDTH / 8 * LINE_BEATS);
    localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG =
        BUS_TAG_WIDTH'(sysbus_tag(SYSBUS_READ, SYSBUS_MEMORY));

    line_fill_state_e          state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0] line_addr_q;
    logic                      start;
    logic                      accept;
    logic                      tag_ok;
    logic                      beat_last;
    logic                      arb_req;
    logic                      busy;
    logic                      req_cyc;
    logic [BUS_DATA_WIDTH-1:0] req;
    logic [BUS_TAG_WIDTH-1:0]  req_tag;
    logic                      resp_ack;
    logic                      line_ready;
    logic                      unused_inputs;

    // A fill can only be launched from rest; enable mid-fill is ignored.
    assign start = enable && ((state_q == IDLE) || (state_q == READY));

`ifdef LINE_FILL_TAGCHK_EN
    assign tag_ok = (bus.main_bus_resptag[BUS_TAG_WIDTH-1 -: 5] == {SYSBUS_READ, SYSBUS_MEMORY});
`else
    assign tag_ok = 1'b1;
`endif

    assign unused_inputs = ^{addr[OFFSET_W-1:0], bus.main_bus_resptag};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                line_addr_q <= {addr[BUS_DATA_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        arb_req    = 1'b0;
        busy       = 1'b0;
        req_cyc    = 1'b0;
        req        = '0;
        req_tag    = '0;
        resp_ack   = 1'b0;
        accept     = 1'b0;
        line_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = ARB;
            end
            ARB: begin
                arb_req = 1'b1;
                if (bus.abtr_grant) state_d = ADDRREQ;
            end
            ADDRREQ: begin
                busy    = 1'b1;
                req_cyc = 1'b1;
                req     = line_addr_q;
                req_tag = READ_TAG;
                if (bus.main_bus_reqack) state_d = WAITRESP;
            end
            WAITRESP, RESP: begin
                busy     = 1'b1;
                accept   = bus.main_bus_respcyc && tag_ok;
                resp_ack = accept;
                if (accept) state_d = beat_last ? READY : RESP;
            end
            READY: begin
                line_ready = 1'b1;
                if (enable) state_d = ARB;
            end
            default: state_d = IDLE;
        endcase
    end

    line_fill_assembler #(
        .BUS_DATA_WIDTH(BUS_DATA_WIDTH),
        .LINE_BEATS    (LINE_BEATS)
    ) u_assembler (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .accept(accept),
        .beat  (bus.main_bus_resp),
        .last  (beat_last),
        .data  (data)
    );

    assign bus.abtr_reqcyc      = arb_req;
    assign bus.bus_busy         = busy;
    assign bus.main_bus_reqcyc  = req_cyc;
    assign bus.main_bus_req     = req;
    assign bus.main_bus_reqtag  = req_tag;
    assign bus.main_bus_respack = resp_ack;
    assign ready                = line_ready;

endmodule

// File: tb/tb_line_fill.sv
// Bench for line_fill: directed fills plus randomized fills, scored against
// a queue-based model of requests and assembled lines.
module tb_line_fill;
    import line_fill_pkg::*;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;
    localparam int LW = DW * NB;
    localparam logic [TW-1:0] READ_TAG = (TW'(SYSBUS_READ) << 12) | (TW'(SYSBUS_MEMORY) << 8);
    localparam logic [TW-1:0] WRITE_TAG = TW'(SYSBUS_WRITE) << 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] addr;
    logic          ready;
    logic [LW-1:0] data;

    line_fill_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus ();

    line_fill #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .LINE_BEATS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .addr  (addr),
        .bus   (bus),
        .ready (ready),
        .data  (data)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_req_q[$];
    logic [LW-1:0] exp_line_q[$];
    logic [DW-1:0] cur_beats[NB];
    int            cur_stalls[NB];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [TW-1:0] good_tag();
`ifdef LINE_FILL_TAGCHK_EN
        return {READ_TAG[TW-1:8], 8'($urandom)};
`else
        return TW'($urandom);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fill transaction; abort_after < NB pulls reset after that many beats.
    task automatic fill(input logic [DW-1:0] a, input int grant_dly, input int ack_dly,
                        input int bad_at, input int abort_after);
        logic [LW-1:0] line;
        for (int k = 0; k < NB; k++) line[k*DW +: DW] = cur_beats[k];
        exp_req_q.push_back(a & ~64'h3f);
        if (abort_after >= NB) exp_line_q.push_back(line);

        enable = 1'b1;
        addr   = a;
        step();
        enable = 1'b0;
        addr   = rand64();
        #1;
        check("arb_reqcyc", LW'(bus.abtr_reqcyc), 1);
        check("ready_drop", LW'(ready), 0);

        for (int i = 0; i < grant_dly; i++) begin
            enable = 1'($urandom_range(0, 1));
            addr   = rand64();
            bus.main_bus_respcyc = 1'($urandom_range(0, 1));
            bus.main_bus_resp    = rand64();
            #1;
            check("arb_hold", LW'(bus.abtr_reqcyc), 1);
            check("arb_respack", LW'(bus.main_bus_respack), 0);
            check("arb_busy", LW'(bus.bus_busy), 0);
            step();
        end
        enable = 1'b0;
        bus.main_bus_respcyc = 1'b0;
        bus.abtr_grant = 1'b1;
        step();
        bus.abtr_grant = 1'b0;

        for (int i = 0; i <= ack_dly; i++) begin
            bus.main_bus_reqack  = (i == ack_dly);
            bus.main_bus_respcyc = 1'($urandom_range(0, 1));
            bus.main_bus_resp    = rand64();
            #1;
            check("addr_reqcyc", LW'(bus.main_bus_reqcyc), 1);
            check("addr_busy", LW'(bus.bus_busy), 1);
            check("addr_respack", LW'(bus.main_bus_respack), 0);
            check("addr_abtr", LW'(bus.abtr_reqcyc), 0);
            step();
        end
        bus.main_bus_reqack  = 1'b0;
        bus.main_bus_respcyc = 1'b0;
        #1;
        check("wait_reqcyc", LW'(bus.main_bus_reqcyc), 0);

        for (int k = 0; k < NB; k++) begin
            if (k == abort_after) begin
                bus.main_bus_respcyc = 1'b1;
                bus.main_bus_resp    = rand64();
                reset = 1'b0;
                #1;
                check("rst_ready", LW'(ready), 0);
                check("rst_data", data, 0);
                check("rst_busy", LW'(bus.bus_busy), 0);
                check("rst_respack", LW'(bus.main_bus_respack), 0);
                check("rst_reqcyc", LW'(bus.main_bus_reqcyc), 0);
                check("rst_abtr", LW'(bus.abtr_reqcyc), 0);
                step();
                bus.main_bus_respcyc = 1'b0;
                step();
                reset = 1'b1;
                step();
                return;
            end
            for (int s = 0; s < cur_stalls[k]; s++) begin
                bus.main_bus_respcyc = 1'b0;
                enable = 1'($urandom_range(0, 1));
                addr   = rand64();
                #1;
                check("stall_respack", LW'(bus.main_bus_respack), 0);
                check("stall_busy", LW'(bus.bus_busy), 1);
                check("stall_abtr", LW'(bus.abtr_reqcyc), 0);
                check("stall_ready", LW'(ready), 0);
                step();
            end
            enable = 1'b0;
            if (k == bad_at) begin
                bus.main_bus_respcyc = 1'b1;
                bus.main_bus_resp    = rand64();
                bus.main_bus_resptag = WRITE_TAG;
                #1;
                check("badtag_respack", LW'(bus.main_bus_respack), 0);
                step();
            end
            bus.main_bus_respcyc = 1'b1;
            bus.main_bus_resp    = cur_beats[k];
            bus.main_bus_resptag = good_tag();
            #1;
            check("beat_respack", LW'(bus.main_bus_respack), 1);
            step();
        end
        bus.main_bus_respcyc = 1'b1;
        bus.main_bus_resp    = rand64();
        #1;
        check("ready_after_last", LW'(ready), 1);
        check("ready_busy", LW'(bus.bus_busy), 0);
        check("ready_respack", LW'(bus.main_bus_respack), 0);
        step();
        bus.main_bus_respcyc = 1'b0;
    endtask

    // Scoreboard monitor: request channel and completed lines.
    initial begin
        logic                 reqcyc_prev = 1'b0;
        logic                 ready_prev  = 1'b0;
        logic [DW+TW-1:0]     held_req    = '0;
        logic [LW-1:0]        held_data   = '0;
        forever begin
            @(negedge clk);
            if (bus.main_bus_reqcyc === 1'b1) begin
                if (!reqcyc_prev) begin
                    if (exp_req_q.size() == 0) begin
                        check("unexpected_req", LW'(bus.main_bus_req), 0);
                    end else begin
                        check("req_addr", LW'(bus.main_bus_req), LW'(exp_req_q.pop_front()));
                        check("req_tag", LW'(bus.main_bus_reqtag), LW'(READ_TAG));
                    end
                end else begin
                    check("req_hold", LW'({bus.main_bus_req, bus.main_bus_reqtag}), LW'(held_req));
                end
                held_req = {bus.main_bus_req, bus.main_bus_reqtag};
            end else begin
                check("req_idle_zero", LW'({bus.main_bus_req, bus.main_bus_reqtag}), 0);
            end
            reqcyc_prev = (bus.main_bus_reqcyc === 1'b1);

            if (ready === 1'b1 && !ready_prev) begin
                if (exp_line_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ready: got ready=1 expected no completed line");
                end else begin
                    check("line_data", data, exp_line_q.pop_front());
                end
                held_data = data;
            end else if (ready === 1'b1) begin
                check("ready_data_stable", data, held_data);
            end
            ready_prev = (ready === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        addr   = '0;
        bus.abtr_grant       = 1'b0;
        bus.main_bus_reqack  = 1'b0;
        bus.main_bus_respcyc = 1'b0;
        bus.main_bus_resp    = '0;
        bus.main_bus_resptag = '0;
        #2;
        check("reset_ready", LW'(ready), 0);
        check("reset_data", data, 0);
        check("reset_abtr", LW'(bus.abtr_reqcyc), 0);
        check("reset_busy", LW'(bus.bus_busy), 0);
        check("reset_reqcyc", LW'(bus.main_bus_reqcyc), 0);
        step();
        step();
        reset = 1'b1;
        step();

        // Basic fill
        for (int k = 0; k < NB; k++) begin
            cur_beats[k]  = DW'(k + 1);
            cur_stalls[k] = 0;
        end
        fill(64'h1234_5678, 2, 0, 99, 99);

        // Stalls between beats 3 and 4; back-to-back from READY
        cur_stalls[3] = 3;
        fill(64'h1234_5678, 2, 0, 99, 99);
        cur_stalls[3] = 0;

        // Late request acknowledge
        fill(rand64(), 1, 5, 99, 99);

        // Reset after beat 5, then a fresh fill
        fill(rand64(), 0, 1, 99, 5);
        for (int k = 0; k < NB; k++) cur_beats[k] = rand64();
        fill(rand64(), 1, 0, 99, 99);

`ifdef LINE_FILL_TAGCHK_EN
        for (int k = 0; k < NB; k++) cur_beats[k] = rand64();
        fill(rand64(), 0, 0, 4, 99);
`endif

        for (int f = 0; f < 20; f++) begin
            int bad;
            for (int k = 0; k < NB; k++) begin
                cur_beats[k]  = rand64();
                cur_stalls[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
`ifdef LINE_FILL_TAGCHK_EN
            bad = int'($urandom_range(0, 11));
`else
            bad = 99;
`endif
            fill(rand64(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bad, 99);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        check("lines_outstanding", LW'(exp_line_q.size()), 0);
        check("reqs_outstanding", LW'(exp_req_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_fill.md
LINE_FILL -- requirements
Module: line_fill

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, SHALL set the system bus beat width in bits.
REQ-002 Parameter BUS_TAG_WIDTH, default 13, SHALL set the bus tag width.
REQ-003 Parameter LINE_BEATS, default 8, SHALL set the data beats per cache line; line width is BUS_DATA_WIDTH*LINE_BEATS (512).
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- enable, in, 1: start a line fill.
- addr, in, BUS_DATA_WIDTH: fill address, any byte offset.
- abtr_reqcyc, out, 1: bus arbiter request.
- abtr_grant, in, 1: arbiter grant.
- bus_busy, out, 1: block owns the bus.
- main_bus_reqcyc, out, 1: request valid.
- main_bus_req, out, BUS_DATA_WIDTH: request payload.
- main_bus_reqtag, out, BUS_TAG_WIDTH: request tag.
- main_bus_reqack, in, 1: request accepted.
- main_bus_respcyc, in, 1: response beat valid.
- main_bus_resp, in, BUS_DATA_WIDTH: response beat.
- main_bus_resptag, in, BUS_TAG_WIDTH: response tag.
- main_bus_respack, out, 1: response beat accepted.
- ready, out, 1: line assembled, data valid.
- data, out, BUS_DATA_WIDTH*LINE_BEATS: assembled line, beat 0 in bits [63:0].

Function
REQ-005 The FSM SHALL have exactly these states: IDLE, ARB, ADDRREQ, WAITRESP, RESP, READY.
REQ-006 IDLE SHALL go to ARB on enable=1; READY SHALL go to ARB on enable=1 and otherwise stay in READY.
REQ-007 On the enable edge, the block SHALL latch line_addr = {addr[63:6], 6'b0}.
REQ-008 ARB SHALL assert abtr_reqcyc=1 and go to ADDRREQ on abtr_grant=1.
REQ-009 ADDRREQ SHALL drive the following, and hold them until main_bus_reqack=1, then go to WAITRESP:
- main_bus_reqcyc=1.
- main_bus_req=line_addr.
- main_bus_reqtag = SYSBUS_READ<<12 | SYSBUS_MEMORY<<8.
REQ-010 Outside ADDRREQ, main_bus_reqcyc, main_bus_req and main_bus_reqtag SHALL be 0.
REQ-011 WAITRESP SHALL go to RESP on the first main_bus_respcyc=1; that beat SHALL be accepted in the same cycle.
REQ-012 main_bus_respack SHALL equal main_bus_respcyc combinationally in WAITRESP and RESP, and SHALL be 0 elsewhere.
REQ-013 An accepted beat k SHALL be written to data[64k+63:64k], and the 4-bit beat counter SHALL increment.
REQ-014 Cycles with respcyc=0 inside RESP SHALL be stalls: counter and data hold.
REQ-015 On acceptance of beat LINE_BEATS-1, the FSM SHALL go to READY; ready SHALL be 1 from the next cycle.
REQ-016 ready SHALL be 1 only in READY, and data SHALL be stable while ready=1.
REQ-017 bus_busy SHALL be 1 in ADDRREQ, WAITRESP and RESP, and 0 elsewhere.
REQ-018 A respcyc pulse arriving while in IDLE, ARB, ADDRREQ or READY SHALL be ignored and not acknowledged.
REQ-019 enable=1 in READY SHALL drop ready on the next cycle and clear the counter; data keeps its old value until overwritten.
REQ-020 enable outside IDLE and READY SHALL be ignored; a fill in progress is never restarted.

Reset
REQ-021 While reset=0, the block SHALL asynchronously force the following, from any state including mid-fill:
- state=IDLE.
- counter=0.
- line_addr=0.
- data=0.
- All outputs=0.
REQ-022 Deasserting reset SHALL resume operation at the first clk edge; no beat from an aborted fill is retained.

Configuration
REQ-023 With macro LINE_FILL_TAGCHK_EN defined, a beat SHALL be accepted and acked only if main_bus_resptag[12:8] equals SYSBUS_READ<<4|SYSBUS_MEMORY; mismatched beats get respack=0 and are treated as a stall.
REQ-024 Without LINE_FILL_TAGCHK_EN, main_bus_resptag SHALL be ignored.

Structure
REQ-025 The shared bus package SHALL hold the following; line_fill imports it:
- SYSBUS_READ, SYSBUS_WRITE, SYSBUS_MEMORY.
- The tag composition function.
- The line_fill state enum.
REQ-026 The block SHALL be built as one sub-module, line_fill_assembler, which holds the beat counter, beat write-enable decode and the data register; the FSM stays in line_fill.

Verification
REQ-027 Bench SHALL cover the following directed scenarios:
- Basic fill: addr=0x1234_5678 with enable; grant after 2 cycles; reqack immediately; 8 back-to-back beats 0x1..0x8 -> main_bus_req=0x1234_5640, data[63:0]=1, data[511:448]=8, ready 1 cycle after beat 8.
- Stalls: respcyc low for 3 cycles between beats 3 and 4 -> respack low during gaps, counter holds, final data identical to basic fill.
- Late ack: reqack delayed 5 cycles -> reqcyc, req and tag held constant for all 6 cycles; bus_busy=1 throughout.
- Reset mid-fill: reset low after beat 5 -> outputs 0 immediately; a new fill after release returns only the new beats.
- Back-to-back: enable in READY -> ready=0 next cycle; abtr_reqcyc=1; second line correct.
- Tag check (LINE_FILL_TAGCHK_EN): a beat with resptag=SYSBUS_WRITE<<12 inserted -> not acked, not written; 8 valid beats still complete the line.
